// File: rtl/seq_multiplier.sv
// seq_multiplier: sequential shift-add multiplier for WIDTH-bit operands.
// It works on unsigned magnitudes and applies the sign in a final fix-up step.
// It handles one multiplier bit per clock behind a start/busy/done handshake.
module seq_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic               negate;

  logic               sign_a;
  logic               sign_b;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;

  // Operand magnitudes; the most negative value maps onto 2^(WIDTH-1), which still fits.
  always_comb begin
    sign_a = signed_mode & A[WIDTH-1];
    sign_b = signed_mode & B[WIDTH-1];
    mag_a  = sign_a ? -A : A;
    mag_b  = sign_b ? -B : B;
  end

  // Handshake FSM plus shift-add datapath, one multiplier bit per clock with the LSB first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      negate  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= {{WIDTH{1'b0}}, mag_a};
            mplier <= mag_b;
            negate <= sign_a ^ sign_b;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          if (mplier[0]) begin
            acc <= acc + mcand;
          end
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          if (cnt == CW'(WIDTH - 1)) begin
            cnt   <= '0;
            state <= FIX;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FIX: begin
          product <= (negate && (acc != '0)) ? -acc : acc;
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed testbench for seq_multiplier: 4-bit and 8-bit instances with hand-computed products.
module tb_seq_multiplier;

  logic        clk;
  logic        rst;

  logic        start4;
  logic        sm4;
  logic [3:0]  a4;
  logic [3:0]  b4;
  logic        busy4;
  logic        done4;
  logic [7:0]  product4;

  logic        start8;
  logic        sm8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        busy8;
  logic        done8;
  logic [15:0] product8;

  int total;
  int bad;
  int lat;
  int pulses;

  seq_multiplier #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .signed_mode(sm4),
    .A(a4), .B(b4), .busy(busy4), .done(done4), .product(product4)
  );

  seq_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
    .A(a8), .B(b8), .busy(busy8), .done(done8), .product(product8)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance past one rising edge; inputs are driven and outputs sampled 1 ns later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
      else begin
        bad++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  // Pulse start on the 4-bit instance for one edge; returns just after edge 0
  task automatic applyStimulus4(input logic sm, input logic [3:0] a, input logic [3:0] b);
    start4 = 1'b1;
    sm4    = sm;
    a4     = a;
    b4     = b;
    step();
    start4 = 1'b0;
    a4     = 4'h0;
    b4     = 4'h0;
  endtask

  task automatic applyStimulus8(input logic sm, input logic [7:0] a, input logic [7:0] b);
    start8 = 1'b1;
    sm8    = sm;
    a8     = a;
    b8     = b;
    step();
    start8 = 1'b0;
    a8     = 8'h00;
    b8     = 8'h00;
  endtask

  // Count edges until done, bounded so a stuck design cannot hang the run
  task automatic waitDone4(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!done4 && n < 30);
  endtask

  task automatic waitDone8(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!done8 && n < 30);
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    rst    = 1'b1;
    start4 = 1'b0; sm4 = 1'b0; a4 = '0; b4 = '0;
    start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
    step();
    step();
    checkOutput("rst_busy", 32'(busy4), 32'd0);
    checkOutput("rst_done", 32'(done4), 32'd0);
    checkOutput("rst_product", 32'(product4), 32'h0);
    checkOutput("rst_product8", 32'(product8), 32'h0);
    rst = 1'b0;
    step();

    // Unsigned 7*5 with busy watched each cycle
    applyStimulus4(1'b0, 4'd7, 4'd5);
    checkOutput("u7x5_busy_e0", 32'(busy4), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      step();
      checkOutput("u7x5_busy_mid", 32'(busy4), 32'd1);
      checkOutput("u7x5_nodone_mid", 32'(done4), 32'd0);
    end
    step();
    checkOutput("u7x5_done", 32'(done4), 32'd1);
    checkOutput("u7x5_busy_end", 32'(busy4), 32'd0);
    checkOutput("u7x5_product", 32'(product4), 32'h23);
    step();
    checkOutput("u7x5_done_clear", 32'(done4), 32'd0);
    checkOutput("u7x5_hold", 32'(product4), 32'h23);

    // Unsigned 3*8, then 15*15 started in the done cycle
    applyStimulus4(1'b0, 4'd3, 4'd8);
    waitDone4(lat);
    checkOutput("u3x8_latency", 32'(lat), 32'd5);
    checkOutput("u3x8_product", 32'(product4), 32'h18);
    applyStimulus4(1'b0, 4'd15, 4'd15);
    checkOutput("b2b_busy", 32'(busy4), 32'd1);
    checkOutput("b2b_done_clear", 32'(done4), 32'd0);
    checkOutput("b2b_hold", 32'(product4), 32'h18);
    waitDone4(lat);
    checkOutput("u15x15_latency", 32'(lat), 32'd5);
    checkOutput("u15x15_product", 32'(product4), 32'hE1);

    // Signed cases
    applyStimulus4(1'b1, 4'hD, 4'h5);
    waitDone4(lat);
    checkOutput("sm3x5_latency", 32'(lat), 32'd5);
    checkOutput("sm3x5_product", 32'(product4), 32'hF1);
    applyStimulus4(1'b1, 4'h8, 4'h8);
    waitDone4(lat);
    checkOutput("sm8xm8_product", 32'(product4), 32'h40);
    applyStimulus4(1'b1, 4'h0, 4'h8);
    waitDone4(lat);
    checkOutput("s0xm8_product", 32'(product4), 32'h00);

    // Start while busy is ignored
    applyStimulus4(1'b0, 4'd2, 4'd3);
    step();
    start4 = 1'b1; a4 = 4'd7; b4 = 4'd7;
    step();
    start4 = 1'b0;
    waitDone4(lat);
    checkOutput("ign_latency", 32'(lat), 32'd3);
    checkOutput("ign_product", 32'(product4), 32'h06);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (done4) pulses++;
    end
    checkOutput("ign_one_pulse", 32'(pulses), 32'd0);
    checkOutput("ign_idle", 32'(busy4), 32'd0);

    // Reset mid-operation discards the result
    applyStimulus4(1'b0, 4'd7, 4'd7);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("midrst_busy", 32'(busy4), 32'd0);
    checkOutput("midrst_done", 32'(done4), 32'd0);
    checkOutput("midrst_product", 32'(product4), 32'h0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (done4) pulses++;
    end
    checkOutput("midrst_no_done", 32'(pulses), 32'd0);
    applyStimulus4(1'b0, 4'd1, 4'd1);
    waitDone4(lat);
    checkOutput("post_rst_product", 32'(product4), 32'h01);

    // rst wins over start on the same edge
    rst = 1'b1;
    start4 = 1'b1; a4 = 4'd3; b4 = 4'd3;
    step();
    rst = 1'b0;
    start4 = 1'b0;
    checkOutput("rst_vs_start_busy", 32'(busy4), 32'd0);

    // 8-bit instance
    applyStimulus8(1'b1, 8'h80, 8'h80);
    waitDone8(lat);
    checkOutput("w8_s_latency", 32'(lat), 32'd9);
    checkOutput("w8_s_product", 32'(product8), 32'h4000);
    applyStimulus8(1'b0, 8'hFF, 8'hFF);
    waitDone8(lat);
    checkOutput("w8_u_latency", 32'(lat), 32'd9);
    checkOutput("w8_u_product", 32'(product8), 32'hFE01);
    applyStimulus8(1'b1, 8'hFF, 8'h03);
    waitDone8(lat);
    checkOutput("w8_sm1x3_product", 32'(product8), 32'hFFFD);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
Parametrised sequential shift-add multiplier. It generalises the team's 4-bit combinational multiplier to WIDTH-bit operands and adds a signed/unsigned mode and a start/busy/done handshake. It processes one multiplier bit per clock and serves datapaths where a full combinational array costs too much area.

Parameters:
WIDTH, 4, operand width in bits (>=2); product is 2*WIDTH bits

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  synchronous active-high reset
start  input  1  request; sampled only when busy=0
signed_mode  input  1  1 = two's-complement operands; 0 = unsigned; sampled with start
A  input  WIDTH  multiplicand; sampled with start
B  input  WIDTH  multiplier; sampled with start
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse; product valid
product  output  2*WIDTH  result; held until the next done

Behaviour:
- Interface: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset values: busy=0, done=0, product=0, state=IDLE, iteration counter=0.
- States:
  - IDLE: waits for start.
  - CALC: runs WIDTH iterations.
  - FIX: applies the sign, writes product, pulses done.
- Timing, with start sampled high in IDLE at edge 0:
  - Edge 0: latch operands and mode; busy=1; go to CALC.
  - Edges 1..WIDTH: one shift-add iteration per edge, LSB of B first.
  - Edge WIDTH+1: write product; done=1; busy=0; return to IDLE.
  - Latency is start-to-done = WIDTH+1 cycles.
- done: high for exactly one cycle. It clears at the next edge unless a new operation completes on that edge.
- start while busy=1: ignored; operands and mode are not re-sampled and there is no side effect.
- start during the done cycle: state is IDLE, so start is accepted. busy=1 at the next edge and done=0 at the next edge. product keeps the last result until the new result is written.
- Signed mode:
  - Operate on magnitudes: |A| and |B| held as WIDTH-bit unsigned values. The most negative value, -2^(WIDTH-1), has magnitude 2^(WIDTH-1), which fits in WIDTH bits.
  - In FIX, the 2*WIDTH-bit product is two's-complement negated when sign(A) XOR sign(B) is 1.
  - A zero result is never negated to a nonzero value.
- Unsigned mode: plain 2*WIDTH-bit unsigned product. The FIX state passes the value through unchanged.
- Overflow: none. The full 2*WIDTH-bit result is always exact in both modes.
- Accumulator: 2*WIDTH bits internally. The counter counts 0..WIDTH-1 and wraps to 0 when CALC exits.
- Reset mid-operation (rst high in any state): on that edge, return to IDLE with busy=0, done=0, product=0. The in-flight result is discarded.
- rst and start high on the same edge: rst wins.
- Operand inputs may change freely after the start edge without affecting the result.

Test Plan:
- WIDTH=4, unsigned: A=4'b0111, B=4'b0101, start 1 cycle -> done at cycle 5 after start, product=8'h23 (35); busy high for cycles 1-5.
- WIDTH=4, unsigned: A=3, B=8 -> product=8'h18. Then A=15, B=15 -> product=8'hE1 (225). The second start is issued in the done cycle and is accepted back-to-back.
- WIDTH=4, signed: A=-3 (4'hD), B=5 -> product=8'hF1 (-15). Then A=-8, B=-8 -> product=8'h40 (64). Then A=0, B=-8 -> product=8'h00.
- WIDTH=4: start A=2, B=3, then start pulsed again with A=7, B=7 at cycle 2 -> second start ignored; product=8'h06; exactly one done pulse.
- WIDTH=4: start A=7, B=7; assert rst at cycle 3 -> next edge busy=0, done=0, product=0, and no done pulse follows. A subsequent start with A=1, B=1 yields product=8'h01.
- WIDTH=8, signed: A=8'h80, B=8'h80 -> product=16'h4000, done 9 cycles after start. Unsigned A=8'hFF, B=8'hFF -> product=16'hFE01.
